// File: rtl/seg7_pkg.sv
// Shared BCD and 7-segment definitions for the front-panel counter.
// Segment codes are active-low {DP,G,F,E,D,C,B,A}.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg7(input bcd_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hD8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with ripple carry/borrow and synchronous clear.
// cout_o depends only on the held value and cin_i, never on en_i.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic up_i,
  input  logic cin_i,
  output bcd_t q_o,
  output logic cout_o
);

  bcd_t q_q, q_d;

  assign cout_o = cin_i & (up_i ? (q_q == 4'd9) : (q_q == 4'd0));
  assign q_o    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (en_i && cin_i) begin
      if (up_i) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/bcd_updown_scan.sv
// BCD up/down counter with multiplexed common-anode display
// and a binary LED mirror of the count.
module bcd_updown_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 12000,
  parameter int SCAN_DIV = 1,
  parameter int SATURATE = 0,
  parameter int BLANK_LZ = 1,
  parameter int BIN_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_up_n,
  input  logic              sw_down_n,
  input  logic              sw_clr_n,
  output logic [BIN_W-1:0]  led_o,
  output logic [7:0]        seg_n,
  output logic [DIGITS-1:0] dig_n,
  output logic              wrap_o
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit SAT = (SATURATE != 0);
  localparam bit BLZ = (BLANK_LZ != 0);

  // {clr, down, up}, active-low, two-flop synchronised
  logic [2:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 3'b111;
      s2_q <= 3'b111;
    end else begin
      s1_q <= {sw_clr_n, sw_down_n, sw_up_n};
      s2_q <= s1_q;
    end
  end

  logic up_act, dn_act, clr_act;

  assign up_act  = ~s2_q[0];
  assign dn_act  = s2_q[0] & ~s2_q[1];
  assign clr_act = s2_q[0] & s2_q[1] & ~s2_q[2];

  logic [TW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == TW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  bcd_t          digs [DIGITS];
  logic [DIGITS:0] cy;
  logic          step, at_end, dig_en, dig_clr;

  assign cy[0]   = 1'b1;
  assign at_end  = cy[DIGITS];
  assign step    = tick & (up_act | dn_act);
  assign dig_en  = step & ~(SAT & at_end);
  assign dig_clr = tick & clr_act;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (dig_clr),
      .en_i   (dig_en),
      .up_i   (up_act),
      .cin_i  (cy[g]),
      .q_o    (digs[g]),
      .cout_o (cy[g+1])
    );
  end

  logic [BIN_W-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;

  assign wrap_d = step & at_end & ~SAT;

  always_comb begin
    led_d = led_q;
    if (dig_clr)     led_d = '0;
    else if (dig_en) led_d = up_act ? led_q + 1'b1 : led_q - 1'b1;
  end

  // zhi[k]: digit k and all higher digits are zero
  logic [DIGITS:0] zhi;

  assign zhi[DIGITS] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_lz
    assign zhi[g] = zhi[g+1] & (digs[g] == 4'd0);
  end

  logic [SW-1:0]     sc_q, sc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              adv;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;

  assign adv  = (sc_q == SW'(SCAN_DIV - 1));
  assign sc_d = adv ? '0 : sc_q + 1'b1;

  always_comb begin
    idx_d = idx_q;
    if (adv) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    seg_d = bcd_to_seg7(digs[idx_q]);
    if (BLZ && (idx_q != '0) && zhi[idx_q]) seg_d = SEG_BLANK;
    dig_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      led_q  <= '0;
      wrap_q <= 1'b0;
      sc_q   <= '0;
      idx_q  <= '0;
      seg_q  <= 8'hC0;
      dig_q  <= ~DIGITS'(1);
    end else begin
      pre_q  <= pre_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
      sc_q   <= sc_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign led_o  = led_q;
  assign wrap_o = wrap_q;
  assign seg_n  = seg_q;
  assign dig_n  = dig_q;

endmodule

// File: tb/tb_bcd_updown_scan.sv
// Bench for bcd_updown_scan: wrap and saturate instances side by side
// against a decimal-arithmetic reference model.
module tb_bcd_updown_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_up_n = 1'b1;
  logic       sw_down_n = 1'b1;
  logic       sw_clr_n = 1'b1;
  logic [7:0] led_w, led_s, seg_w, seg_s;
  logic [3:0] dig_w, dig_s;
  logic       wrap_w, wrap_s;

  int checks = 0;
  int errors = 0;
  int vw, vs, lw, ls, ph;

  logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  bcd_updown_scan #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(1),
    .SATURATE(0), .BLANK_LZ(1), .BIN_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sw_up_n(sw_up_n),
    .sw_down_n(sw_down_n), .sw_clr_n(sw_clr_n),
    .led_o(led_w), .seg_n(seg_w), .dig_n(dig_w), .wrap_o(wrap_w));

  bcd_updown_scan #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(1),
    .SATURATE(1), .BLANK_LZ(1), .BIN_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .sw_up_n(sw_up_n),
    .sw_down_n(sw_down_n), .sw_clr_n(sw_clr_n),
    .led_o(led_s), .seg_n(seg_s), .dig_n(dig_s), .wrap_o(wrap_s));

  function automatic logic [7:0] seg_exp(input int v, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (pos > 0 && v / p == 0) return 8'hFF;
    return tbl[(v / p) % 10];
  endfunction

  task automatic model(input bit up, input bit dn, input bit clr,
                       input bit sat, input int vi, input int li,
                       output int vo, output int lo, output bit w);
    vo = vi; lo = li; w = 1'b0;
    if (up) begin
      if (vi == 9999) begin
        if (!sat) begin vo = 0; lo = (li + 1) % 256; w = 1'b1; end
      end else begin
        vo = vi + 1; lo = (li + 1) % 256;
      end
    end else if (dn) begin
      if (vi == 0) begin
        if (!sat) begin vo = 9999; lo = (li + 255) % 256; w = 1'b1; end
      end else begin
        vo = vi - 1; lo = (li + 255) % 256;
      end
    end else if (clr) begin
      vo = 0; lo = 0;
    end
  endtask

  // One full tick period; entered just after an update edge.
  task automatic run_tick(input bit up, input bit dn, input bit clr,
                          input bit glitch);
    int pw, ps, plw, pls;
    bit ww, ws;
    logic [3:0] ed;
    pw = vw; ps = vs; plw = lw; pls = ls;
    model(up, dn, clr, 1'b0, pw, plw, vw, lw, ww);
    model(up, dn, clr, 1'b1, ps, pls, vs, ls, ws);
    sw_up_n   = glitch ? up  : ~up;
    sw_down_n = glitch ? dn  : ~dn;
    sw_clr_n  = glitch ? clr : ~clr;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        sw_up_n = ~up; sw_down_n = ~dn; sw_clr_n = ~clr;
      end
      ed = ~(4'b0001 << ph);
      checks += 2;
      if (dig_w !== ed) begin
        errors++;
        $display("FAIL dig_w: got %h want %h", dig_w, ed);
      end
      if (dig_s !== ed) begin
        errors++;
        $display("FAIL dig_s: got %h want %h", dig_s, ed);
      end
      checks += 2;
      if (seg_w !== seg_exp(pw, ph)) begin
        errors++;
        $display("FAIL seg_w pos%0d val%0d: got %h want %h",
                 ph, pw, seg_w, seg_exp(pw, ph));
      end
      if (seg_s !== seg_exp(ps, ph)) begin
        errors++;
        $display("FAIL seg_s pos%0d val%0d: got %h want %h",
                 ph, ps, seg_s, seg_exp(ps, ph));
      end
      ph = (ph + 1) % 4;
      checks += 4;
      if (wrap_w !== ((c == 4) ? ww : 1'b0)) begin
        errors++;
        $display("FAIL wrap_w c%0d: got %b want %b", c, wrap_w,
                 (c == 4) ? ww : 1'b0);
      end
      if (wrap_s !== ((c == 4) ? ws : 1'b0)) begin
        errors++;
        $display("FAIL wrap_s c%0d: got %b want %b", c, wrap_s,
                 (c == 4) ? ws : 1'b0);
      end
      if (led_w !== 8'((c == 4) ? lw : plw)) begin
        errors++;
        $display("FAIL led_w c%0d: got %0d want %0d", c, led_w,
                 (c == 4) ? lw : plw);
      end
      if (led_s !== 8'((c == 4) ? ls : pls)) begin
        errors++;
        $display("FAIL led_s c%0d: got %0d want %0d", c, led_s,
                 (c == 4) ? ls : pls);
      end
    end
  endtask

  task automatic check_rst(input string tag);
    checks += 4;
    if (led_w !== 8'h00 || led_s !== 8'h00) begin
      errors++;
      $display("FAIL %s led: got %h/%h want 00", tag, led_w, led_s);
    end
    if (seg_w !== 8'hC0 || seg_s !== 8'hC0) begin
      errors++;
      $display("FAIL %s seg: got %h/%h want c0", tag, seg_w, seg_s);
    end
    if (dig_w !== 4'hE || dig_s !== 4'hE) begin
      errors++;
      $display("FAIL %s dig: got %h/%h want e", tag, dig_w, dig_s);
    end
    if (wrap_w !== 1'b0 || wrap_s !== 1'b0) begin
      errors++;
      $display("FAIL %s wrap: got %b/%b want 0", tag, wrap_w, wrap_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;
    vw = 0; vs = 0; lw = 0; ls = 0; ph = 0;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 11; i++) run_tick(1, 0, 0, 0);
    run_tick(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    run_tick(0, 0, 1, 0);
    run_tick(0, 1, 0, 0);
    run_tick(0, 0, 0, 0);
    run_tick(1, 0, 0, 0);
    run_tick(0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    run_tick(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_tick(0, 1, 0, 0);
    for (int i = 0; i < 101; i++) run_tick(1, 0, 0, 0);
    run_tick(0, 0, 0, 0);
  endtask

  task automatic test_up_down();
    for (int i = 0; i < 3; i++) run_tick(1, 1, 0, 0);
    run_tick(0, 0, 1, 0);
    run_tick(1, 1, 1, 0);
    run_tick(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_tick(1, 1, 0, 0);
    run_tick(0, 0, 1, 0);
    run_tick(0, 0, 0, 0);
  endtask

  task automatic test_blank();
    for (int i = 0; i < 7; i++) run_tick(1, 0, 0, 0);
    run_tick(0, 0, 0, 0);
    run_tick(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit u, d, c;
    for (int i = 0; i < 150; i++) begin
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 9) == 0);
      run_tick(u, d, c, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back_reset();
    run_tick(0, 0, 1, 0);
    for (int i = 0; i < 42; i++) run_tick(1, 0, 0, 0);
    @(posedge clk); #3;
    sw_up_n = 1'b0;
    rst_n = 1'b0;
    #1;
    check_rst("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vw = 0; vs = 0; lw = 0; ls = 0; ph = 0;
    run_tick(1, 0, 0, 0);
    run_tick(0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_up_down();
    test_blank();
    test_random();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
